// File: rtl/bldc_supervised_driver_pkg.sv
// Shared BLDC types: rotation direction, hall codes and supervisor states,
// plus the microsecond-to-cycle conversion used by the timers.
package bldc_supervised_driver_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_CW   = 2'd1,
        DIR_CCW  = 2'd2
    } rotation_direction_t;

    typedef enum logic [2:0] {
        HALL_INVALID_0 = 3'd0,
        HALL_S1        = 3'd1,
        HALL_S2        = 3'd2,
        HALL_S3        = 3'd3,
        HALL_S4        = 3'd4,
        HALL_S5        = 3'd5,
        HALL_S6        = 3'd6,
        HALL_INVALID_7 = 3'd7
    } hall_states_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RAMP       = 3'd1,
        ST_RUN        = 3'd2,
        ST_STOP       = 3'd3,
        ST_GATE_RESET = 3'd4,
        ST_HOLDOFF    = 3'd5,
        ST_LOCKOUT    = 3'd6,
        ST_ERROR      = 3'd7
    } supervisor_state_t;

    localparam int HZ_PER_MHZ = 1_000_000;
    localparam int US_PER_MS  = 1_000;

    // Assumes sys_clk is an integer number of MHz.
    function automatic int us_to_cycles(input int clk_freq_hz, input int period_us);
        return (clk_freq_hz / HZ_PER_MHZ) * period_us;
    endfunction

endpackage

// File: rtl/bldc_supervised_driver_tick_gen.sv
// Microsecond-parametrised prescaler: one-cycle tick every period_us, restartable.
// Restart wins over the tick so a restart in the expiry cycle re-arms the full period.
module bldc_tick_gen
    import bldc_supervised_driver_pkg::*;
#(
    parameter int clk_freq_hz = 54_000_000,
    parameter int period_us   = 1
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int PERIOD_CYCLES = us_to_cycles(clk_freq_hz, period_us);
    localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    assign tick = !restart && (count_r == LAST);

    // Cycle counter, cleared on restart and on each expiry.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (restart || (count_r == LAST)) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bldc_supervised_driver.sv
// BLDC supervisor: ramps duty, forces a stop before reversal, detects stalls,
// and retries gate-driver faults a bounded number of times before locking out.
module bldc_supervised_driver
    import bldc_supervised_driver_pkg::*;
#(
    parameter int clk_freq_hz      = 54_000_000,
    parameter int duty_width       = 10,
    parameter int ramp_step        = 1,
    parameter int ramp_interval_us = 100,
    parameter int stall_timeout_ms = 50,
    parameter int stop_timeout_ms  = 20,
    parameter int retry_holdoff_ms = 10,
    parameter int max_retries      = 3,
    localparam int RETRY_W = (max_retries > 0) ? $clog2(max_retries + 1) : 1
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  rotation_direction_t     direction,
    input  logic [duty_width-1:0]   duty_target,
    input  logic                    hall_edge,
    input  logic                    hall_error,
    input  logic                    fault_n,
    input  logic                    reset_done,
    output logic [duty_width-1:0]   duty_cmd,
    output rotation_direction_t     dir_cmd,
    output logic                    pwm_enable,
    output logic                    brake,
    output logic                    gate_reset_start,
    output supervisor_state_t       state,
    output logic [RETRY_W-1:0]      retry_count,
    output logic                    lockout
);

    localparam logic [RETRY_W-1:0]  RETRY_MAX = RETRY_W'(max_retries);
    localparam logic [duty_width:0] STEP      = (duty_width + 1)'(ramp_step);

    supervisor_state_t      state_r, state_next_s;
    rotation_direction_t    dir_cmd_r, dir_next_s;
    logic [duty_width-1:0]  duty_cmd_r, duty_next_s, duty_stepped_s;
    logic [RETRY_W-1:0]     retry_count_r, retry_next_s;
    logic                   pwm_enable_r, brake_r, grs_r, lockout_r;
    logic                   grs_next_s, fault_req_s, active_s;
    logic                   ramp_tick_s, stall_tick_s, quiet_tick_s, holdoff_tick_s;
    logic                   ramp_restart_s, stall_restart_s, quiet_restart_s, holdoff_restart_s;

    // Moves cur one step toward tgt without overshooting or wrapping.
    function automatic logic [duty_width-1:0] ramp_toward(
        input logic [duty_width-1:0] cur,
        input logic [duty_width-1:0] tgt
    );
        logic [duty_width:0] gap;
        if (cur < tgt) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            ramp_toward = (gap > STEP) ? cur + STEP[duty_width-1:0] : tgt;
        end else if (cur > tgt) begin
            gap = {1'b0, cur} - {1'b0, tgt};
            ramp_toward = (gap > STEP) ? cur - STEP[duty_width-1:0] : tgt;
        end else begin
            ramp_toward = cur;
        end
    endfunction

    assign active_s          = (state_r == ST_RAMP) || (state_r == ST_RUN);
    assign ramp_restart_s    = !active_s;
    assign stall_restart_s   = !active_s || (duty_cmd_r == {duty_width{1'b0}}) || hall_edge;
    assign quiet_restart_s   = (state_r != ST_STOP) || hall_edge;
    assign holdoff_restart_s = (state_r != ST_HOLDOFF);

    bldc_tick_gen #(.clk_freq_hz(clk_freq_hz), .period_us(ramp_interval_us)) u_ramp_tick (
        .sys_clk(sys_clk), .reset_n(reset_n), .restart(ramp_restart_s), .tick(ramp_tick_s)
    );
    bldc_tick_gen #(.clk_freq_hz(clk_freq_hz), .period_us(stall_timeout_ms * US_PER_MS)) u_stall_tick (
        .sys_clk(sys_clk), .reset_n(reset_n), .restart(stall_restart_s), .tick(stall_tick_s)
    );
    bldc_tick_gen #(.clk_freq_hz(clk_freq_hz), .period_us(stop_timeout_ms * US_PER_MS)) u_quiet_tick (
        .sys_clk(sys_clk), .reset_n(reset_n), .restart(quiet_restart_s), .tick(quiet_tick_s)
    );
    bldc_tick_gen #(.clk_freq_hz(clk_freq_hz), .period_us(retry_holdoff_ms * US_PER_MS)) u_holdoff_tick (
        .sys_clk(sys_clk), .reset_n(reset_n), .restart(holdoff_restart_s), .tick(holdoff_tick_s)
    );

    assign duty_stepped_s = ramp_tick_s ? ramp_toward(duty_cmd_r, duty_target) : duty_cmd_r;

    // Next-state and next-output decode; duty is forced to zero outside RAMP/RUN.
    always_comb begin
        state_next_s = state_r;
        duty_next_s  = {duty_width{1'b0}};
        dir_next_s   = dir_cmd_r;
        retry_next_s = retry_count_r;
        grs_next_s   = 1'b0;
        fault_req_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hall_error) begin
                    state_next_s = ST_ERROR;
                end else if (enable && (direction != DIR_NONE)) begin
                    dir_next_s   = direction;
                    state_next_s = ST_RAMP;
                end else if (!enable) begin
                    retry_next_s = {RETRY_W{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RAMP, ST_RUN: begin
                if (hall_error) begin
                    state_next_s = ST_ERROR;
                end else if (!fault_n || stall_tick_s) begin
                    fault_req_s = 1'b1;
                end else if (!enable || (direction != dir_cmd_r)) begin
                    state_next_s = ST_STOP;
                end else begin
                    duty_next_s = duty_stepped_s;
                    if ((state_r == ST_RAMP) && (duty_stepped_s == duty_target)) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = state_r;
                    end
                end
            end
            ST_STOP: begin
                if (quiet_tick_s) begin
                    state_next_s = ST_IDLE;
                    dir_next_s   = DIR_NONE;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_GATE_RESET: begin
                if (reset_done) begin
                    state_next_s = ST_HOLDOFF;
                end else begin
                    state_next_s = ST_GATE_RESET;
                end
            end
            ST_HOLDOFF: begin
                if (!holdoff_tick_s) begin
                    state_next_s = ST_HOLDOFF;
                end else if (!fault_n) begin
                    fault_req_s = 1'b1;
                end else if (enable && (direction == dir_cmd_r) && !hall_error) begin
                    state_next_s = ST_RAMP;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_LOCKOUT: begin
                if (!enable) begin
                    state_next_s = ST_IDLE;
                    retry_next_s = {RETRY_W{1'b0}};
                end else begin
                    state_next_s = ST_LOCKOUT;
                end
            end
            ST_ERROR: begin
                if (!hall_error) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ERROR;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (fault_req_s) begin
            if (retry_count_r == RETRY_MAX) begin
                state_next_s = ST_LOCKOUT;
            end else begin
                retry_next_s = retry_count_r + RETRY_W'(1);
                grs_next_s   = 1'b1;
                state_next_s = ST_GATE_RESET;
            end
        end else begin
            grs_next_s = 1'b0;
        end
    end

    // State and output registers; flags decode from the next state so they align with it.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            duty_cmd_r    <= {duty_width{1'b0}};
            dir_cmd_r     <= DIR_NONE;
            retry_count_r <= {RETRY_W{1'b0}};
            pwm_enable_r  <= 1'b0;
            brake_r       <= 1'b0;
            grs_r         <= 1'b0;
            lockout_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            duty_cmd_r    <= duty_next_s;
            dir_cmd_r     <= dir_next_s;
            retry_count_r <= retry_next_s;
            pwm_enable_r  <= (state_next_s == ST_RAMP) || (state_next_s == ST_RUN);
            brake_r       <= (state_next_s == ST_STOP);
            grs_r         <= grs_next_s;
            lockout_r     <= (state_next_s == ST_LOCKOUT);
        end
    end

    assign state            = state_r;
    assign duty_cmd         = duty_cmd_r;
    assign dir_cmd          = dir_cmd_r;
    assign retry_count      = retry_count_r;
    assign pwm_enable       = pwm_enable_r;
    assign brake            = brake_r;
    assign gate_reset_start = grs_r;
    assign lockout          = lockout_r;

endmodule
